// File: rtl/k12_nonce_dispatcher_if.sv
// Signal bundle between k12_nonce_dispatcher, the job host, the K12 cores and the result consumer.
// slave: the dispatcher side; master: the environment driving jobs, core results and res_ready.
interface k12_nonce_dispatcher_if #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned NONCE_W   = 64
);
  logic                         job_load;
  logic                         job_abort;
  logic [575:0]                 job_blob;
  logic [63:0]                  job_target;
  logic [NONCE_W-1:0]           job_nonce;
  logic [31:0]                  job_count;
  logic                         job_busy;
  logic                         job_done;
  logic [NUM_CORES-1:0]         core_load;
  logic [NUM_CORES*NONCE_W-1:0] core_nonce;
  logic [575:0]                 core_blob;
  logic [63:0]                  core_target;
  logic [NUM_CORES-1:0]         core_store;
  logic [NUM_CORES*256-1:0]     core_hash;
  logic                         res_valid;
  logic                         res_ready;
  logic [NONCE_W-1:0]           res_nonce;
  logic [63:0]                  res_hash_hi;
  logic [31:0]                  stat_hashes;
  logic [31:0]                  stat_hits;

  modport slave (
    input  job_load, job_abort, job_blob, job_target, job_nonce, job_count,
    input  core_store, core_hash, res_ready,
    output job_busy, job_done, core_load, core_nonce, core_blob, core_target,
    output res_valid, res_nonce, res_hash_hi, stat_hashes, stat_hits
  );

  modport master (
    output job_load, job_abort, job_blob, job_target, job_nonce, job_count,
    output core_store, core_hash, res_ready,
    input  job_busy, job_done, core_load, core_nonce, core_blob, core_target,
    input  res_valid, res_nonce, res_hash_hi, stat_hashes, stat_hits
  );
endinterface

// File: rtl/k12_nonce_dispatcher.sv
// Round-robin nonce dispatcher for K12 PoW cores with target compare and winning-nonce FIFO.
// Optional per-job counters are built when K12_DISPATCH_STATS_EN is defined.
module k12_nonce_dispatcher #(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned NONCE_W    = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  k12_nonce_dispatcher_if.slave  bus
);
  localparam int unsigned PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_t;

  state_t                            r_state, w_state_nxt;
  logic [575:0]                      r_blob;
  logic [63:0]                       r_target;
  logic [NONCE_W-1:0]                r_nonce;
  logic [31:0]                       r_remaining;
  logic [PW-1:0]                     r_ptr;
  logic [NUM_CORES-1:0]              r_busy;
  logic [NUM_CORES-1:0]              r_pend;
  logic [NUM_CORES-1:0][NONCE_W-1:0] r_core_nonce;
  logic [NUM_CORES-1:0][63:0]        r_pend_hi;
  logic [NONCE_W-1:0]                r_fifo_nonce [FIFO_DEPTH];
  logic [63:0]                       r_fifo_hi    [FIFO_DEPTH];
  logic [AW:0]                       r_wr_ptr, r_rd_ptr;

  logic [NUM_CORES-1:0][63:0]        w_hash_hi;
  logic [NUM_CORES-1:0][NONCE_W-1:0] w_core_nonce;
  logic [NUM_CORES-1:0]              w_free, w_accept, w_hit, w_load;
  logic                              w_job_acc, w_sel_vld, w_issue;
  logic                              w_push_vld, w_push, w_pop, w_full, w_empty;
  logic [PW-1:0]                     w_sel, w_push_sel;
  logic [AW:0]                       w_count;
  logic                              w_unused;

  // Only the top 64 bits of each core hash take part in the target compare.
  assign w_unused = ^bus.core_hash;

  always_comb begin
    w_hash_hi = '0;
    w_hit     = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      w_hash_hi[i] = bus.core_hash[i*256+192 +: 64];
      w_hit[i]     = w_hash_hi[i] < r_target;
    end
  end

  // A core holding an unwritten hit is not free even though its hash is done.
  assign w_free    = ~(r_busy | r_pend);
  assign w_accept  = bus.core_store & r_busy;
  assign w_job_acc = (r_state == S_IDLE) && bus.job_load;

  always_comb begin
    w_sel     = '0;
    w_sel_vld = 1'b0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      if (!w_sel_vld && w_free[PW'((32'(r_ptr) + k) % NUM_CORES)]) begin
        w_sel_vld = 1'b1;
        w_sel     = PW'((32'(r_ptr) + k) % NUM_CORES);
      end
    end
  end

  assign w_issue = (r_state == S_DISPATCH) && !bus.job_abort &&
                   (r_remaining != '0) && w_sel_vld;

  always_comb begin
    w_push_sel = '0;
    w_push_vld = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (!w_push_vld && r_pend[i]) begin
        w_push_vld = 1'b1;
        w_push_sel = PW'(i);
      end
    end
  end

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop   = !w_empty && bus.res_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push  = w_push_vld && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    bus.job_busy = 1'b0;
    bus.job_done = 1'b0;
    w_load       = '0;
    if (w_issue) w_load[w_sel] = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        if (bus.job_load) w_state_nxt = (bus.job_count == '0) ? S_DRAIN : S_DISPATCH;
      end
      S_DISPATCH: begin
        bus.job_busy = 1'b1;
        if (bus.job_abort || (r_remaining == '0) || (w_issue && r_remaining == 32'd1))
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        bus.job_busy = 1'b1;
        if ((r_busy | r_pend) == '0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.job_done = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blob      <= '0;
      r_target    <= '0;
      r_nonce     <= '0;
      r_remaining <= '0;
      r_ptr       <= '0;
    end else if (w_job_acc) begin
      r_blob      <= bus.job_blob;
      r_target    <= bus.job_target;
      r_nonce     <= bus.job_nonce;
      r_remaining <= bus.job_count;
      r_ptr       <= '0;
    end else if (w_issue) begin
      r_nonce     <= r_nonce + NONCE_W'(1);
      r_remaining <= r_remaining - 32'd1;
      r_ptr       <= (32'(w_sel) == NUM_CORES - 1) ? '0 : w_sel + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy       <= '0;
      r_pend       <= '0;
      r_core_nonce <= '0;
      r_pend_hi    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (w_load[i]) begin
          r_busy[i]       <= 1'b1;
          r_core_nonce[i] <= r_nonce;
        end else if (w_accept[i]) begin
          r_busy[i] <= 1'b0;
          if (w_hit[i]) begin
            r_pend[i]    <= 1'b1;
            r_pend_hi[i] <= w_hash_hi[i];
          end
        end
        if (w_push && (w_push_sel == PW'(i))) r_pend[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_nonce[r_wr_ptr[AW-1:0]] <= r_core_nonce[w_push_sel];
      r_fifo_hi[r_wr_ptr[AW-1:0]]    <= r_pend_hi[w_push_sel];
    end
  end

  // The loading core sees the new nonce in its load cycle, then the held copy.
  always_comb begin
    w_core_nonce = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++)
      w_core_nonce[i] = w_load[i] ? r_nonce : r_core_nonce[i];
  end

  assign bus.core_load   = w_load;
  assign bus.core_nonce  = w_core_nonce;
  assign bus.core_blob   = r_blob;
  assign bus.core_target = r_target;
  assign bus.res_valid   = !w_empty;
  assign bus.res_nonce   = w_empty ? '0 : r_fifo_nonce[r_rd_ptr[AW-1:0]];
  assign bus.res_hash_hi = w_empty ? '0 : r_fifo_hi[r_rd_ptr[AW-1:0]];

`ifdef K12_DISPATCH_STATS_EN
  localparam int unsigned CW = $clog2(NUM_CORES + 1);

  logic [31:0]   r_stat_hashes, r_stat_hits;
  logic [CW-1:0] w_acc_cnt;
  logic [32:0]   w_hash_sum;

  always_comb begin
    w_acc_cnt = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++)
      w_acc_cnt = w_acc_cnt + CW'(w_accept[i]);
  end

  assign w_hash_sum = {1'b0, r_stat_hashes} + 33'(w_acc_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_hashes <= '0;
      r_stat_hits   <= '0;
    end else if (w_job_acc) begin
      r_stat_hashes <= '0;
      r_stat_hits   <= '0;
    end else begin
      r_stat_hashes <= w_hash_sum[32] ? '1 : w_hash_sum[31:0];
      if (w_push && (r_stat_hits != '1)) r_stat_hits <= r_stat_hits + 32'd1;
    end
  end

  assign bus.stat_hashes = r_stat_hashes;
  assign bus.stat_hits   = r_stat_hits;
`else
  assign bus.stat_hashes = '0;
  assign bus.stat_hits   = '0;
`endif
endmodule
